// File: rtl/ahb_apb_bridge_p.sv
// AHB-Lite to APB bridge: one transfer at a time, all outputs registered or
// decoded from state, PSEL chosen by an address slot field, ACCESS timeout.
module ahb_apb_bridge_p #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int NUM_PSEL = 4,
  parameter int SLOT_LSB = 12,
  parameter int TIMEOUT  = 16
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic                HSEL,
  input  logic [ADDR_W-1:0]   HADDR,
  input  logic                HWRITE,
  input  logic [1:0]          HTRANS,
  input  logic                HREADYIN,
  input  logic [DATA_W-1:0]   HWDATA,
  output logic                HREADYOUT,
  output logic                HRESP,
  output logic [DATA_W-1:0]   HRDATA,
  output logic [NUM_PSEL-1:0] PSEL,
  output logic                PENABLE,
  output logic [ADDR_W-1:0]   PADDR,
  output logic                PWRITE,
  output logic [DATA_W-1:0]   PWDATA,
  input  logic [DATA_W-1:0]   PRDATA,
  input  logic                PREADY,
  input  logic                PSLVERR
);

  localparam int SEL_W = (NUM_PSEL > 1) ? $clog2(NUM_PSEL) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 2);
  localparam logic [SEL_W:0]   NUM_PSEL_V = (SEL_W + 1)'(NUM_PSEL);
  localparam logic [CNT_W-1:0] TO_LAST    = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE, S_WDATA, S_SETUP, S_ACCESS, S_ERR1, S_ERR2
  } state_t;

  state_t           state, state_nx;
  logic [SEL_W-1:0] idx, idx_in;
  logic [CNT_W-1:0] cnt;
  logic             valid, accept, in_range;

  assign valid    = HSEL & HREADYIN & ((HTRANS == 2'b10) | (HTRANS == 2'b11));
  assign accept   = valid & ((state == S_IDLE) | (state == S_ERR2));
  assign idx_in   = (NUM_PSEL == 1) ? '0 : HADDR[SLOT_LSB +: SEL_W];
  assign in_range = ({1'b0, idx_in} < NUM_PSEL_V);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state  <= S_IDLE;
      idx    <= '0;
      cnt    <= '0;
      PADDR  <= '0;
      PWRITE <= 1'b0;
      PWDATA <= '0;
      HRDATA <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        PADDR  <= HADDR;
        PWRITE <= HWRITE;
        idx    <= idx_in;
      end
      if (state == S_WDATA) PWDATA <= HWDATA;
      // counter holds the number of ACCESS cycles already spent waiting
      if (state == S_SETUP) cnt <= '0;
      else if (state == S_ACCESS && !PREADY) cnt <= cnt + 1'b1;
      if (state == S_ACCESS && PREADY && !PSLVERR && !PWRITE) HRDATA <= PRDATA;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_ERR2: begin
        if (valid) begin
          if (!in_range)   state_nx = S_ERR1;
          else if (HWRITE) state_nx = S_WDATA;
          else             state_nx = S_SETUP;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_WDATA: state_nx = S_SETUP;
      S_SETUP: state_nx = S_ACCESS;
      S_ACCESS: begin
        // a slave answering on the last allowed cycle still completes normally
        if (PREADY)                               state_nx = PSLVERR ? S_ERR1 : S_IDLE;
        else if (TIMEOUT > 0 && cnt == TO_LAST)   state_nx = S_ERR1;
      end
      S_ERR1:  state_nx = S_ERR2;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    PSEL      = '0;
    PENABLE   = 1'b0;
    HREADYOUT = 1'b0;
    HRESP     = 1'b0;
    case (state)
      S_IDLE:   HREADYOUT = 1'b1;
      S_SETUP:  PSEL = NUM_PSEL'(1) << idx;
      S_ACCESS: begin
        PSEL    = NUM_PSEL'(1) << idx;
        PENABLE = 1'b1;
      end
      S_ERR1:   HRESP = 1'b1;
      S_ERR2: begin
        HRESP     = 1'b1;
        HREADYOUT = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahb_apb_bridge_p.sv
// Directed bench for ahb_apb_bridge_p: a transaction-timeline model predicts
// every cycle's outputs; extra instances cover NUM_PSEL=1 and NUM_PSEL=3.
module tb_ahb_apb_bridge_p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, hsel, hwrite, hreadyin, pready, pslverr;
  logic [1:0]  htrans;
  logic [31:0] haddr, hwdata, prdata;
  logic        hreadyout, hresp, penable, pwrite;
  logic [31:0] hrdata, paddr, pwdata;
  logic [3:0]  psel;

  logic        h1_ready, h1_resp, h1_pen, p1_write, h1_psel;
  logic [31:0] h1_rdata, p1_addr, p1_wdata;

  logic        d3_hsel, d3_hwrite, d3_hreadyin, d3_pready, d3_pslverr;
  logic [1:0]  d3_htrans;
  logic [31:0] d3_haddr, d3_hwdata, d3_prdata;
  logic        d3_hready, d3_hresp, d3_pen, d3_pwrite;
  logic [31:0] d3_hrdata, d3_paddr, d3_pwdata;
  logic [2:0]  d3_psel;

  ahb_apb_bridge_p u_dut (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel), .HADDR(haddr), .HWRITE(hwrite),
    .HTRANS(htrans), .HREADYIN(hreadyin), .HWDATA(hwdata),
    .HREADYOUT(hreadyout), .HRESP(hresp), .HRDATA(hrdata),
    .PSEL(psel), .PENABLE(penable), .PADDR(paddr), .PWRITE(pwrite), .PWDATA(pwdata),
    .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr));

  ahb_apb_bridge_p #(.NUM_PSEL(1)) u_dut1 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel), .HADDR(haddr), .HWRITE(hwrite),
    .HTRANS(htrans), .HREADYIN(hreadyin), .HWDATA(hwdata),
    .HREADYOUT(h1_ready), .HRESP(h1_resp), .HRDATA(h1_rdata),
    .PSEL(h1_psel), .PENABLE(h1_pen), .PADDR(p1_addr), .PWRITE(p1_write), .PWDATA(p1_wdata),
    .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr));

  ahb_apb_bridge_p #(.NUM_PSEL(3)) u_dut3 (
    .HCLK(clk), .HRESET(rst), .HSEL(d3_hsel), .HADDR(d3_haddr), .HWRITE(d3_hwrite),
    .HTRANS(d3_htrans), .HREADYIN(d3_hreadyin), .HWDATA(d3_hwdata),
    .HREADYOUT(d3_hready), .HRESP(d3_hresp), .HRDATA(d3_hrdata),
    .PSEL(d3_psel), .PENABLE(d3_pen), .PADDR(d3_paddr), .PWRITE(d3_pwrite), .PWDATA(d3_pwdata),
    .PRDATA(d3_prdata), .PREADY(d3_pready), .PSLVERR(d3_pslverr));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Expected outputs for the cycle following one clock edge
  typedef struct packed {
    logic [3:0]  psel;
    logic        pen;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;
  } exp_t;

  typedef enum {K_IDLE, K_WDATA, K_SETUP, K_ACCESS, K_ERR1, K_ERR2} kind_t;

  exp_t        q[$];
  logic [31:0] m_paddr, m_pwdata, m_hrdata;
  logic        m_pwrite;
  int          m_idx;

  int         run = 0, last_run = 0;
  logic [3:0] run_psel = '0, last_psel = '0;

  // Push what the bus must look like after the next edge, then take that edge.
  task automatic step(input kind_t k);
    exp_t e;
    e.psel   = (k == K_SETUP || k == K_ACCESS) ? (4'b0001 << m_idx) : 4'b0000;
    e.pen    = (k == K_ACCESS);
    e.hready = (k == K_IDLE || k == K_ERR2);
    e.hresp  = (k == K_ERR1 || k == K_ERR2);
    e.paddr  = m_paddr;
    e.pwrite = m_pwrite;
    e.pwdata = m_pwdata;
    e.hrdata = m_hrdata;
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic model_reset();
    m_paddr = '0; m_pwrite = 1'b0; m_pwdata = '0; m_hrdata = '0; m_idx = 0;
  endtask

  task automatic bus_idle();
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hreadyin = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    bus_idle();
    for (int i = 0; i < n; i++) step(K_IDLE);
  endtask

  // One AHB transfer; slave answers after 'waits' ACCESS wait cycles.
  // rst_at >= 0 pulses reset during that ACCESS cycle instead.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                      input logic [31:0] rd, input int waits, input logic err, input int rst_at);
    bit done;
    hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr; hreadyin = 1'b1;
    m_paddr = addr; m_pwrite = wr; m_idx = int'(addr[13:12]);
    if (wr) begin
      step(K_WDATA);
      bus_idle();
      hwdata = wd; m_pwdata = wd;
    end
    step(K_SETUP);
    bus_idle();
    prdata = rd; pready = 1'b0; pslverr = 1'b0;
    step(K_ACCESS);
    done = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      if (k == rst_at) begin
        rst = 1'b1; model_reset();
        step(K_IDLE);
        rst = 1'b0; done = 1;
      end else if (k == waits) begin
        pready = 1'b1; pslverr = err;
        if (err) begin
          step(K_ERR1);
          pready = 1'b0; pslverr = 1'b0;
          step(K_ERR2);
        end else begin
          if (!wr) m_hrdata = rd;
          step(K_IDLE);
          pready = 1'b0;
        end
        done = 1;
      end else if (k + 1 == 16) begin
        step(K_ERR1);
        step(K_ERR2);
        done = 1;
      end else begin
        step(K_ACCESS);
      end
    end
  endtask

  initial begin : compare
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("psel", 64'(psel), 64'(e.psel));
        chk("penable", 64'(penable), 64'(e.pen));
        chk("paddr", 64'(paddr), 64'(e.paddr));
        chk("pwrite", 64'(pwrite), 64'(e.pwrite));
        chk("pwdata", 64'(pwdata), 64'(e.pwdata));
        chk("hrdata", 64'(hrdata), 64'(e.hrdata));
        chk("hreadyout", 64'(hreadyout), 64'(e.hready));
        chk("hresp", 64'(hresp), 64'(e.hresp));
        chk("np1_psel", 64'(h1_psel), 64'(e.psel != 4'b0000));
        chk("np1_penable", 64'(h1_pen), 64'(e.pen));
        chk("np1_hreadyout", 64'(h1_ready), 64'(e.hready));
        chk("np1_hresp", 64'(h1_resp), 64'(e.hresp));
        chk("np1_hrdata", 64'(h1_rdata), 64'(e.hrdata));
      end
      if (hreadyout === 1'b0) begin
        run++;
        run_psel |= psel;
      end else if (run > 0) begin
        last_run = run; last_psel = run_psel;
        run = 0; run_psel = '0;
      end
    end
  end

  initial begin : stim
    rst = 1'b1; hsel = 1'b0; htrans = 2'b00; haddr = '0; hwrite = 1'b0; hreadyin = 1'b1;
    hwdata = '0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    d3_hsel = 1'b0; d3_htrans = 2'b00; d3_haddr = '0; d3_hwrite = 1'b0; d3_hreadyin = 1'b1;
    d3_hwdata = '0; d3_prdata = '0; d3_pready = 1'b0; d3_pslverr = 1'b0;
    model_reset();
    step(K_IDLE);
    step(K_IDLE);
    rst = 1'b0;
    chk("reset_hreadyout", 64'(hreadyout), 64'd1);
    chk("reset_psel", 64'(psel), 64'd0);

    // ignored: BUSY, IDLE, HREADYIN low, HSEL low
    hsel = 1'b1; hreadyin = 1'b1; htrans = 2'b01; haddr = 32'h0000_1004; hwrite = 1'b1;
    step(K_IDLE);
    htrans = 2'b00; step(K_IDLE);
    htrans = 2'b10; hreadyin = 1'b0; step(K_IDLE);
    hreadyin = 1'b1; hsel = 1'b0; step(K_IDLE);
    idle_cycles(1);

    xfer(32'h0000_1004, 1'b1, 32'hCAFE_F00D, 32'h0, 0, 1'b0, -1);
    chk("wr_low_cycles", 64'(last_run), 64'd3);
    chk("wr_psel", 64'(last_psel), 64'b0010);
    chk("wr_pwdata", 64'(pwdata), 64'hCAFE_F00D);
    chk("wr_hresp", 64'(hresp), 64'd0);
    idle_cycles(1);

    xfer(32'h0000_3000, 1'b0, 32'h0, 32'h1234_5678, 2, 1'b0, -1);
    chk("rd_wait_low_cycles", 64'(last_run), 64'd4);
    chk("rd_wait_psel", 64'(last_psel), 64'b1000);
    chk("rd_wait_hrdata", 64'(hrdata), 64'h1234_5678);

    xfer(32'h0000_2008, 1'b0, 32'h0, 32'hA5A5_0001, 0, 1'b0, -1);
    chk("rd_low_cycles", 64'(last_run), 64'd2);
    chk("rd_hrdata", 64'(hrdata), 64'hA5A5_0001);

    xfer(32'h0000_0010, 1'b0, 32'h0, 32'hDEAD_BEEF, 0, 1'b1, -1);
    chk("slverr_hresp_err2", 64'(hresp), 64'd1);
    chk("slverr_hready_err2", 64'(hreadyout), 64'd1);
    chk("slverr_low_cycles", 64'(last_run), 64'd3);
    chk("slverr_hrdata_kept", 64'(hrdata), 64'hA5A5_0001);
    idle_cycles(1);

    xfer(32'h0000_0000, 1'b1, 32'h1111_2222, 32'h0, 1, 1'b0, -1);
    chk("wr_wait_low_cycles", 64'(last_run), 64'd4);

    // timeout, then a write accepted straight out of ERR2
    xfer(32'h0000_1000, 1'b0, 32'h0, 32'h0000_0077, 1000, 1'b0, -1);
    chk("timeout_low_cycles", 64'(last_run), 64'd18);
    chk("timeout_hresp", 64'(hresp), 64'd1);
    xfer(32'h0000_2004, 1'b1, 32'h0BAD_CAFE, 32'h0, 0, 1'b0, -1);
    chk("b2b_low_cycles", 64'(last_run), 64'd3);
    chk("b2b_hresp", 64'(hresp), 64'd0);
    chk("b2b_hrdata_kept", 64'(hrdata), 64'hA5A5_0001);

    // PREADY on the final allowed ACCESS cycle completes normally
    xfer(32'h0000_1008, 1'b0, 32'h0, 32'h5555_AAAA, 15, 1'b0, -1);
    chk("to_edge_low_cycles", 64'(last_run), 64'd17);
    chk("to_edge_hrdata", 64'(hrdata), 64'h5555_AAAA);
    idle_cycles(1);

    xfer(32'h0000_3004, 1'b0, 32'h0, 32'h0000_0099, 5, 1'b0, 2);
    chk("rst_paddr", 64'(paddr), 64'd0);
    chk("rst_psel", 64'(psel), 64'd0);
    chk("rst_hrdata", 64'(hrdata), 64'd0);
    idle_cycles(2);
    xfer(32'h0000_2000, 1'b0, 32'h0, 32'h600D_0000, 1, 1'b0, -1);
    chk("post_rst_low_cycles", 64'(last_run), 64'd3);
    chk("post_rst_hrdata", 64'(hrdata), 64'h600D_0000);
    idle_cycles(1);

    // NUM_PSEL=3: slot 3 has no slave
    d3_hsel = 1'b1; d3_htrans = 2'b10; d3_haddr = 32'h0000_3000; d3_hwrite = 1'b0;
    step(K_IDLE);
    d3_hsel = 1'b0; d3_htrans = 2'b00;
    chk("np3_err1_psel", 64'(d3_psel), 64'b000);
    chk("np3_err1_hresp", 64'(d3_hresp), 64'd1);
    chk("np3_err1_hready", 64'(d3_hready), 64'd0);
    step(K_IDLE);
    chk("np3_err2_psel", 64'(d3_psel), 64'b000);
    chk("np3_err2_hresp", 64'(d3_hresp), 64'd1);
    chk("np3_err2_hready", 64'(d3_hready), 64'd1);
    step(K_IDLE);
    chk("np3_idle_hresp", 64'(d3_hresp), 64'd0);
    d3_hsel = 1'b1; d3_htrans = 2'b10; d3_haddr = 32'h0000_2000;
    d3_pready = 1'b1; d3_prdata = 32'h0000_3333;
    step(K_IDLE);
    d3_hsel = 1'b0; d3_htrans = 2'b00;
    chk("np3_setup_psel", 64'(d3_psel), 64'b100);
    chk("np3_setup_pen", 64'(d3_pen), 64'd0);
    step(K_IDLE);
    chk("np3_access_psel", 64'(d3_psel), 64'b100);
    chk("np3_access_pen", 64'(d3_pen), 64'd1);
    step(K_IDLE);
    chk("np3_hrdata", 64'(d3_hrdata), 64'h0000_3333);
    chk("np3_done_psel", 64'(d3_psel), 64'b000);
    chk("np3_done_hready", 64'(d3_hready), 64'd1);
    idle_cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
